// File: rtl/traffic_light_fsm_param.sv
// Parametrised traffic/pedestrian light controller clocked by the 1 Hz seconds_clk.
// Define FLASH_MODE_EN to add the flash_en input and the flashing FLASH state.
module traffic_light_fsm_param #(
  parameter int CNT_W    = 5,
  parameter int T_INIT   = 12,
  parameter int T_GREEN  = 6,
  parameter int T_EXT    = 3,
  parameter int T_YELLOW = 2,
  parameter int T_WALK   = 3,
  parameter int MAX_EXT  = 1
) (
  input  logic       seconds_clk,
  input  logic       rst,
  input  logic       sensor,
  input  logic       walk_req,
`ifdef FLASH_MODE_EN
  input  logic       flash_en,
`endif
  output logic       Gm,
  output logic       Ym,
  output logic       Rm,
  output logic       Gs,
  output logic       Ys,
  output logic       Rs,
  output logic       walk_lamp,
  output logic       walk_pending,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_INIT  = 4'd0,
    S_GMI   = 4'd1,
    S_YM    = 4'd2,
    S_GS    = 4'd3,
    S_GSE   = 4'd4,
    S_YS    = 4'd5,
    S_GMA   = 4'd6,
    S_GME   = 4'd7,
    S_WALK  = 4'd8,
    S_FLASH = 4'd9
  } state_t;

  typedef struct packed {
    logic gm, ym, rm, gs, ys, rs, walk;
  } lamps_t;

  localparam int EXT_W = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);

  // Last timer value of each phase; a phase of length T exits when timer == T-1.
  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] EXT_LAST    = CNT_W'(T_EXT - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(T_WALK - 1);
  localparam logic [EXT_W-1:0] EXT_LIMIT   = EXT_W'(MAX_EXT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [EXT_W-1:0] ext_cnt_q, ext_cnt_d;
  logic             walk_pending_q, walk_pending_d;
  lamps_t           lamps_q, lamps_d;
  logic             restart;
  logic             ext_ok;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d        = state_q;
    ext_cnt_d      = ext_cnt_q;
    restart        = 1'b0;
    ext_ok         = sensor && (ext_cnt_q < EXT_LIMIT);

    case (state_q)
      S_INIT: begin
        state_d = S_GMI;
        restart = 1'b1;
      end
      S_GMI: if (timer_q == INIT_LAST) begin
        state_d = S_YM;
        restart = 1'b1;
      end
      S_YM: if (timer_q == YELLOW_LAST) begin
        state_d = (walk_pending_q || walk_req) ? S_WALK : S_GS;
        restart = 1'b1;
      end
      S_WALK: if (timer_q == WALK_LAST) begin
        state_d = S_GS;
        restart = 1'b1;
      end
      S_GS: if (timer_q == GREEN_LAST) begin
        state_d = ext_ok ? S_GSE : S_YS;
        restart = 1'b1;
      end
      S_GSE: if (timer_q == EXT_LAST) begin
        state_d = ext_ok ? S_GSE : S_YS;
        restart = 1'b1;
      end
      S_YS: if (timer_q == YELLOW_LAST) begin
        state_d = S_GMA;
        restart = 1'b1;
      end
      S_GMA: if (timer_q == GREEN_LAST) begin
        state_d = ext_ok ? S_GME : S_YM;
        restart = 1'b1;
      end
      S_GME: if (timer_q == EXT_LAST) begin
        state_d = ext_ok ? S_GME : S_YM;
        restart = 1'b1;
      end
      default: begin
        // FLASH with flash_en released, and any unreachable code, falls back to INIT.
        state_d   = S_INIT;
        restart   = 1'b1;
        ext_cnt_d = '0;
      end
    endcase

    if (restart) begin
      case (state_d)
        S_GSE, S_GME: ext_cnt_d = ext_cnt_q + EXT_W'(1);
        S_YS, S_YM:   ext_cnt_d = '0;
        default:      ;
      endcase
    end

    timer_d = restart ? '0 : timer_q + CNT_W'(1);

    // Entering WALK consumes the request and wins over a same-edge set.
    walk_pending_d = walk_pending_q || (walk_req && (state_q != S_WALK));
    if (restart && (state_d == S_WALK)) walk_pending_d = 1'b0;

`ifdef FLASH_MODE_EN
    if (flash_en) begin
      state_d        = S_FLASH;
      timer_d        = (state_q == S_FLASH) ? timer_q + CNT_W'(1) : '0;
      ext_cnt_d      = '0;
      walk_pending_d = 1'b0;
    end
`endif

    // Lamps are registered from the next state so they always match state_q.
    lamps_d = '0;
    case (state_d)
      S_GMI, S_GMA, S_GME: begin lamps_d.gm = 1'b1; lamps_d.rs = 1'b1; end
      S_YM:                begin lamps_d.ym = 1'b1; lamps_d.rs = 1'b1; end
      S_GS, S_GSE:         begin lamps_d.gs = 1'b1; lamps_d.rm = 1'b1; end
      S_YS:                begin lamps_d.ys = 1'b1; lamps_d.rm = 1'b1; end
      S_WALK: begin
        lamps_d.rm   = 1'b1;
        lamps_d.rs   = 1'b1;
        lamps_d.walk = 1'b1;
      end
`ifdef FLASH_MODE_EN
      S_FLASH: begin
        lamps_d.ym = ~timer_d[0];
        lamps_d.rs = ~timer_d[0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge seconds_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q        <= S_INIT;
      timer_q        <= '0;
      ext_cnt_q      <= '0;
      walk_pending_q <= 1'b0;
      lamps_q        <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      ext_cnt_q      <= ext_cnt_d;
      walk_pending_q <= walk_pending_d;
      lamps_q        <= lamps_d;
    end
  end

  assign Gm           = lamps_q.gm;
  assign Ym           = lamps_q.ym;
  assign Rm           = lamps_q.rm;
  assign Gs           = lamps_q.gs;
  assign Ys           = lamps_q.ys;
  assign Rs           = lamps_q.rs;
  assign walk_lamp    = lamps_q.walk;
  assign walk_pending = walk_pending_q;
  assign state_out    = state_q;

endmodule
